// File: rtl/axi_node_pkg.sv
// Shared types and helpers for the AXI node write-data path.
//   wdisp_state_t   : write-data dispatcher FSM states
//   lowest_set_bit  : isolates the least-significant set bit of a vector (0 stays 0)
package axi_node_pkg;

    typedef enum logic [1:0] {
        WD_IDLE  = 2'd0,
        WD_ROUTE = 2'd1,
        WD_SINK  = 2'd2
    } wdisp_state_t;

    // Two's-complement trick: v & -v keeps only the lowest set bit.
    function automatic logic [63:0] lowest_set_bit(input logic [63:0] v);
        return v & (~v + 64'd1);
    endfunction

endpackage

// File: rtl/axi_wdest_fifo.sv
// Synchronous FIFO holding normalised routing vectors (no fall-through).
//   clk, rst   : clock, synchronous active-high reset
//   push_i     : write data_i (ignored when full)
//   data_i     : routing vector; stored as its lowest set bit
//   pop_i      : drop the head entry (ignored when empty)
//   head_o     : current head entry
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
//   count_o    : occupancy
module axi_wdest_fifo
    import axi_node_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        push_ok = push_i & ~full_o;
        pop_ok  = pop_i & ~empty_o;
        mem_d   = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = WIDTH'(lowest_set_bit(64'(data_i)));
        end
        // DEPTH is a power of two, so pointers wrap on overflow.
        wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
        rd_ptr_d = rd_ptr_q + PtrW'(pop_ok);
        count_d  = count_q + CntW'(push_ok) - CntW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/axi_wdata_dispatcher.sv
// Write-data dispatcher: queues AW routing decisions and steers W valid/ready/last
// control to the selected master port; sinks the beats of a rejected burst.
//   clk, rst                : clock, synchronous active-high reset
//   push_DEST_i, DEST_i     : routing decision from the AW decoder
//   grant_FIFO_DEST_o       : a push will be accepted this cycle
//   wvalid_i, wlast_i       : W beat control from the slave side
//   wready_o                : W beat accepted (combinational)
//   wvalid_o, wready_i      : per master-port W handshake
//   handle_error_i          : sink the next burst (sampled only in IDLE)
//   wdata_error_completed_o : one-cycle pulse on the last sunk beat
//   fifo_count_o            : routing FIFO occupancy
module axi_wdata_dispatcher
    import axi_node_pkg::*;
#(
    parameter int unsigned N_INIT_PORT = 8,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_DEST_i,
    input  logic [N_INIT_PORT-1:0]        DEST_i,
    output logic                          grant_FIFO_DEST_o,
    input  logic                          wvalid_i,
    input  logic                          wlast_i,
    output logic                          wready_o,
    output logic [N_INIT_PORT-1:0]        wvalid_o,
    input  logic [N_INIT_PORT-1:0]        wready_i,
    input  logic                          handle_error_i,
    output logic                          wdata_error_completed_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    wdisp_state_t           state_q, state_d;
    logic [N_INIT_PORT-1:0] head;
    logic                   fifo_full, fifo_empty;
    logic [CntW-1:0]        fifo_count;
    logic                   push_taken;
    logic                   pop;

    axi_wdest_fifo #(
        .WIDTH (N_INIT_PORT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_DEST_i),
        .data_i  (DEST_i),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign grant_FIFO_DEST_o = ~fifo_full;
    assign fifo_count_o      = fifo_count;
    assign push_taken        = push_DEST_i & ~fifo_full;

    always_comb begin
        state_d                 = state_q;
        wvalid_o                = '0;
        wready_o                = 1'b0;
        pop                     = 1'b0;
        wdata_error_completed_o = 1'b0;
        unique case (state_q)
            WD_IDLE: begin
                // Entering ROUTE on the push itself lets the first beat go one
                // cycle after the push, when the entry reaches the head.
                if (!fifo_empty || push_taken) begin
                    state_d = WD_ROUTE;
                end else if (handle_error_i) begin
                    state_d = WD_SINK;
                end
            end
            WD_ROUTE: begin
                wvalid_o = head & {N_INIT_PORT{wvalid_i}};
                wready_o = |(head & wready_i);
                pop      = wvalid_i & wready_o & wlast_i;
                // Leave only when the popped entry was the last one queued.
                if (pop && fifo_count == CntW'(1) && !push_taken) begin
                    state_d = WD_IDLE;
                end
            end
            WD_SINK: begin
                wready_o = 1'b1;
                if (wvalid_i && wlast_i) begin
                    wdata_error_completed_o = ~rst;
                    state_d                 = WD_IDLE;
                end
            end
            default: state_d = WD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        push_DEST_i |-> grant_FIFO_DEST_o);
    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
        pop |-> !fifo_empty);
    a_wvalid_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(wvalid_o));
    a_no_zero_dest: assert property (@(posedge clk) disable iff (rst)
        (state_q == WD_ROUTE) |-> (head != '0));

endmodule

// File: tb/tb_axi_wdata_dispatcher.sv
module tb_axi_wdata_dispatcher;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         push_DEST_i;
    logic [N-1:0] DEST_i;
    logic         grant_FIFO_DEST_o;
    logic         wvalid_i;
    logic         wlast_i;
    logic         wready_o;
    logic [N-1:0] wvalid_o;
    logic [N-1:0] wready_i;
    logic         handle_error_i;
    logic         wdata_error_completed_o;
    logic [2:0]   fifo_count_o;

    axi_wdata_dispatcher #(
        .N_INIT_PORT (N),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .push_DEST_i             (push_DEST_i),
        .DEST_i                  (DEST_i),
        .grant_FIFO_DEST_o       (grant_FIFO_DEST_o),
        .wvalid_i                (wvalid_i),
        .wlast_i                 (wlast_i),
        .wready_o                (wready_o),
        .wvalid_o                (wvalid_o),
        .wready_i                (wready_i),
        .handle_error_i          (handle_error_i),
        .wdata_error_completed_o (wdata_error_completed_o),
        .fifo_count_o            (fifo_count_o)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of pending routes, a "sinking" flag, and a
    // one-cycle pause after a sink ends before queued routes are served.
    logic [N-1:0] mq [$];
    bit           m_sink = 1'b0;
    bit           m_gap  = 1'b0;

    function automatic logic [N-1:0] norm(input logic [N-1:0] v);
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                r[i] = 1'b1;
                break;
            end
        end
        return r;
    endfunction

    function automatic bit m_serve();
        return (mq.size() != 0) && !m_sink && !m_gap;
    endfunction

    function automatic logic [N-1:0] m_wvalid();
        return m_serve() ? (mq[0] & {N{wvalid_i}}) : '0;
    endfunction

    function automatic logic m_wready();
        return m_serve() ? |(mq[0] & wready_i) : m_sink;
    endfunction

    function automatic logic m_done();
        return m_sink && wvalid_i && wlast_i && !rst;
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_sink = 1'b0;
            m_gap  = 1'b0;
        end else begin
            bit sv, pop, done;
            int size_now;
            sv       = m_serve();
            pop      = sv && m_wready() && wvalid_i && wlast_i;
            done     = m_sink && wvalid_i && wlast_i;
            size_now = mq.size();
            if (pop) void'(mq.pop_front());
            if (push_DEST_i && size_now < D) mq.push_back(norm(DEST_i));
            if (m_sink) begin
                m_sink = !done;
                m_gap  = done;
            end else begin
                m_gap = 1'b0;
                if (!sv && mq.size() == 0 && handle_error_i) m_sink = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (check_en) begin
            chk("model_wvalid", 8'(wvalid_o), 8'(m_wvalid()));
            chk("model_wready", 8'(wready_o), 8'(m_wready()));
            chk("model_done", 8'(wdata_error_completed_o), 8'(m_done()));
            chk("model_grant", 8'(grant_FIFO_DEST_o), 8'(mq.size() < D));
            chk("model_count", 8'(fifo_count_o), 8'(mq.size()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; push_DEST_i = 1'b0; DEST_i = '0; wvalid_i = 1'b0; wlast_i = 1'b0;
        wready_i = '0; handle_error_i = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_en = 1'b1;
        #1;
        chk("rst_grant", 8'(grant_FIFO_DEST_o), 8'h01);
        chk("rst_count", 8'(fifo_count_o), 8'h00);
        chk("rst_wready", 8'(wready_o), 8'h00);
        chk("rst_wvalid", 8'(wvalid_o), 8'h00);

        // 1: single 3-beat burst to port 2
        push_DEST_i = 1'b1; DEST_i = 4'b0100;
        tick();
        push_DEST_i = 1'b0; wvalid_i = 1'b1; wready_i = 4'b0100; wlast_i = 1'b0;
        #1;
        chk("t1_b1_wvalid", 8'(wvalid_o), 8'h04);
        chk("t1_b1_wready", 8'(wready_o), 8'h01);
        chk("t1_b1_count", 8'(fifo_count_o), 8'h01);
        tick(); #1;
        chk("t1_b2_wvalid", 8'(wvalid_o), 8'h04);
        tick(); wlast_i = 1'b1; #1;
        chk("t1_b3_wvalid", 8'(wvalid_o), 8'h04);
        chk("t1_b3_count", 8'(fifo_count_o), 8'h01);
        tick(); wvalid_i = 1'b0; wlast_i = 1'b0; wready_i = '0; #1;
        chk("t1_end_count", 8'(fifo_count_o), 8'h00);
        chk("t1_end_wvalid", 8'(wvalid_o), 8'h00);

        // 2: two bursts streamed back-to-back
        push_DEST_i = 1'b1; DEST_i = 4'b0010;
        tick();
        DEST_i = 4'b1000; wvalid_i = 1'b1; wready_i = 4'b1111; wlast_i = 1'b0; #1;
        chk("t2_b1_wvalid", 8'(wvalid_o), 8'h02);
        tick(); push_DEST_i = 1'b0; wlast_i = 1'b1; #1;
        chk("t2_b2_wvalid", 8'(wvalid_o), 8'h02);
        tick(); wlast_i = 1'b0; #1;
        chk("t2_b3_wvalid", 8'(wvalid_o), 8'h08);
        tick(); wlast_i = 1'b1; #1;
        chk("t2_b4_wvalid", 8'(wvalid_o), 8'h08);
        tick(); wvalid_i = 1'b0; wlast_i = 1'b0; #1;
        chk("t2_end_count", 8'(fifo_count_o), 8'h00);

        // 3: fill the FIFO, then free one slot
        wready_i = '0;
        for (int i = 0; i < D; i++) begin
            push_DEST_i = 1'b1; DEST_i = 4'(1 << i);
            tick();
        end
        push_DEST_i = 1'b0; #1;
        chk("t3_full_grant", 8'(grant_FIFO_DEST_o), 8'h00);
        chk("t3_full_count", 8'(fifo_count_o), 8'h04);
        wvalid_i = 1'b1; wlast_i = 1'b1; wready_i = 4'b0001; #1;
        chk("t3_pop_grant", 8'(grant_FIFO_DEST_o), 8'h00);
        chk("t3_pop_wready", 8'(wready_o), 8'h01);
        tick(); wvalid_i = 1'b0; #1;
        chk("t3_after_grant", 8'(grant_FIFO_DEST_o), 8'h01);
        chk("t3_after_count", 8'(fifo_count_o), 8'h03);
        wvalid_i = 1'b1; wready_i = 4'b1111;
        repeat (3) tick();
        wvalid_i = 1'b0; wlast_i = 1'b0; wready_i = '0; #1;
        chk("t3_drain_count", 8'(fifo_count_o), 8'h00);

        // 4: sink a rejected 2-beat burst
        handle_error_i = 1'b1;
        tick();
        handle_error_i = 1'b0; wvalid_i = 1'b1; wlast_i = 1'b0; #1;
        chk("t4_b1_wready", 8'(wready_o), 8'h01);
        chk("t4_b1_wvalid", 8'(wvalid_o), 8'h00);
        chk("t4_b1_done", 8'(wdata_error_completed_o), 8'h00);
        tick(); wlast_i = 1'b1; #1;
        chk("t4_b2_done", 8'(wdata_error_completed_o), 8'h01);
        tick(); wvalid_i = 1'b0; wlast_i = 1'b0; #1;
        chk("t4_end_done", 8'(wdata_error_completed_o), 8'h00);
        chk("t4_end_wready", 8'(wready_o), 8'h00);

        // 5: multi-bit DEST normalised; stalled port must not leak
        push_DEST_i = 1'b1; DEST_i = 4'b0110;
        tick();
        push_DEST_i = 1'b0; wvalid_i = 1'b1; wlast_i = 1'b1; wready_i = 4'b0100;
        repeat (5) begin
            #1;
            chk("t5_hold_wvalid", 8'(wvalid_o), 8'h02);
            chk("t5_hold_wready", 8'(wready_o), 8'h00);
            tick();
        end
        wready_i = 4'b0010; #1;
        chk("t5_accept_wready", 8'(wready_o), 8'h01);
        tick(); wvalid_i = 1'b0; wlast_i = 1'b0; wready_i = '0; #1;
        chk("t5_end_count", 8'(fifo_count_o), 8'h00);

        // 7: push during a sink is held until the sink finishes
        handle_error_i = 1'b1;
        tick();
        handle_error_i = 1'b0; push_DEST_i = 1'b1; DEST_i = 4'b1000;
        wvalid_i = 1'b1; wlast_i = 1'b0; #1;
        chk("t7_sink_wvalid", 8'(wvalid_o), 8'h00);
        tick(); push_DEST_i = 1'b0; wlast_i = 1'b1; #1;
        chk("t7_sink_done", 8'(wdata_error_completed_o), 8'h01);
        chk("t7_sink_count", 8'(fifo_count_o), 8'h01);
        tick(); wready_i = 4'b1000; #1;
        chk("t7_gap_wvalid", 8'(wvalid_o), 8'h00);
        chk("t7_gap_wready", 8'(wready_o), 8'h00);
        tick(); #1;
        chk("t7_route_wvalid", 8'(wvalid_o), 8'h08);
        chk("t7_route_wready", 8'(wready_o), 8'h01);
        tick(); wvalid_i = 1'b0; wlast_i = 1'b0; wready_i = '0; #1;
        chk("t7_end_count", 8'(fifo_count_o), 8'h00);

        // 6: reset in the middle of a burst with two routes queued
        push_DEST_i = 1'b1; DEST_i = 4'b0001;
        tick();
        DEST_i = 4'b0010;
        tick();
        push_DEST_i = 1'b0; wvalid_i = 1'b1; wlast_i = 1'b0; wready_i = 4'b1111; #1;
        chk("t6_pre_count", 8'(fifo_count_o), 8'h02);
        chk("t6_pre_wvalid", 8'(wvalid_o), 8'h01);
        tick();
        rst = 1'b1;
        tick(); #1;
        chk("t6_rst_count", 8'(fifo_count_o), 8'h00);
        chk("t6_rst_wvalid", 8'(wvalid_o), 8'h00);
        chk("t6_rst_grant", 8'(grant_FIFO_DEST_o), 8'h01);
        chk("t6_rst_done", 8'(wdata_error_completed_o), 8'h00);
        rst = 1'b0; wvalid_i = 1'b0; wready_i = '0;
        tick(); #1;
        chk("t6_post_count", 8'(fifo_count_o), 8'h00);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
